sram_bist: RTL and testbench
============================

SRAM_BIST -- requirements
Module: sram_bist

Interface
- REQ-001 The block SHALL have parameter DATA_W, default 32, bus data width in bits.
- REQ-002 The block SHALL have parameter ADDR_W, default 10, word-address width (SRAM_ADDR_W-2).
- REQ-003 The block SHALL have parameter PATTERN, default 32'hA5C3_0F96, DATA_W-bit base test pattern.
- REQ-004 The block SHALL have these ports:
  - clk_i  in  1  clock
  - arst_i  in  1  reset; one clock, synchronous, active-high
  - cke_i  in  1  clock enable; low holds all state
  - start_i  in  1  start pulse
  - len_i  in  ADDR_W+1  words to test, from address 0
  - busy_o  out  1  test running
  - done_o  out  1  test finished; held until next accepted start
  - pass_o  out  1  no mismatch; valid while done_o
  - err_cnt_o  out  16  mismatch count, saturating
  - fail_addr_o  out  ADDR_W  first mismatching word address
  - avalid_o  out  1  bus request valid
  - addr_o  out  ADDR_W  word address
  - wdata_o  out  DATA_W  write data
  - wstrb_o  out  DATA_W/8  byte strobes; nonzero = write
  - rdata_i  in  DATA_W  read data
  - rvalid_i  in  1  read data valid
  - ready_i  in  1  request accepted when avalid_o&ready_i

Function
- REQ-005 The block SHALL be an IOb-native initiator driving one SRAM data or instruction port.
- REQ-006 Pattern for word a SHALL be P(a)=PATTERN^a, with a zero-extended to DATA_W.
- REQ-007 FSM states SHALL be IDLE, WRITE, RD_REQ, RD_WAIT, DONE.
- REQ-008 In IDLE, start_i=1 with len_i!=0 SHALL clear err_cnt_o, fail_addr_o and the address counter, clear done_o, and enter WRITE next cycle.
- REQ-009 start_i with len_i==0 SHALL go directly to DONE with pass_o=1 and no bus request.
- REQ-010 start_i outside IDLE and DONE SHALL be ignored; start_i in DONE SHALL behave as in IDLE.
- REQ-011 WRITE SHALL hold avalid_o=1, wstrb_o=all-ones, addr_o=a, wdata_o=P(a).
  - On acceptance, a SHALL increment.
  - The next write SHALL issue back-to-back in the following cycle.
  - After address len_i-1 is accepted, a SHALL reset to 0 and the FSM SHALL enter RD_REQ.
- REQ-012 RD_REQ SHALL assert avalid_o=1, wstrb_o=0, addr_o=a; on acceptance the FSM SHALL enter RD_WAIT.
- REQ-013 Only one read SHALL be outstanding at a time.
- REQ-014 In RD_WAIT, avalid_o SHALL be 0; on rvalid_i:
  - rdata_i!=P(a) SHALL increment err_cnt_o (saturating at 16'hFFFF).
  - On the first mismatch, a SHALL be latched to fail_addr_o.
  - Then, if a==len_i-1, the FSM SHALL enter DONE; otherwise a SHALL increment and the FSM SHALL return to RD_REQ.
- REQ-015 avalid_o, addr_o, wdata_o and wstrb_o SHALL stay stable while avalid_o=1 and ready_i=0.
- REQ-016 rvalid_i outside RD_WAIT SHALL be ignored.
- REQ-017 DONE SHALL set done_o=1, busy_o=0 and pass_o=(err_cnt_o==0); busy_o SHALL be 1 in all states other than IDLE and DONE.
- REQ-018 len_i SHALL be sampled at start; later changes SHALL be ignored.
- REQ-019 len_i>2^ADDR_W SHALL be clamped to 2^ADDR_W.

Reset
- REQ-020 With arst_i=1 at a clock edge, the FSM SHALL go to IDLE and the following SHALL be 0: avalid_o, wstrb_o, addr_o, wdata_o, busy_o, done_o, pass_o, err_cnt_o, fail_addr_o.
- REQ-021 Reset mid-test SHALL abort the test, with avalid_o low from the following cycle.
- REQ-022 A late rvalid_i after reset SHALL be ignored.
- REQ-023 arst_i SHALL take priority over cke_i.

Configuration
- REQ-024 With IOB_SOC_SUT_BIST_INV_PASS_EN defined, after the first read pass the block SHALL run a second WRITE and read pass over the same range using ~P(a), then enter DONE.
  - err_cnt_o SHALL accumulate across both passes.
  - fail_addr_o SHALL record the first mismatch from either pass.
- REQ-025 Without IOB_SOC_SUT_BIST_INV_PASS_EN, only the single P(a) pass SHALL run, and no inversion logic or pass flag SHALL be synthesized.

Structure
- REQ-026 FSM state encodings and the 16-bit error-counter width SHALL reside in a shared package, sram_bist_pkg.
- REQ-027 The pattern generate/compare function SHALL be one sub-module, sram_bist_cmp, computing P(a), optional inversion and the mismatch flag combinationally.
- REQ-028 All registers SHALL use iob_reg-style instances or equivalent synchronous-reset flops.

Verification
- REQ-029 The bench SHALL connect ADDR_W=4 to a model SRAM with ready=1 and 1-cycle rvalid, and cover these scenarios:
  - REQ-030 len_i=16, start -> 16 back-to-back writes P(0..15), then 16 reads; done_o=1, pass_o=1, err_cnt_o=0.
  - REQ-031 Word 5 stuck at bit0 flipped, len_i=16 -> done_o=1, pass_o=0, err_cnt_o=1, fail_addr_o=5.
  - REQ-032 ready_i low for 3 cycles during the write of address 2 -> request held stable, no skipped or duplicated address.
  - REQ-033 len_i=0 -> done_o=1 and pass_o=1 within 2 cycles, avalid_o never asserted.
  - REQ-034 arst_i pulsed in RD_WAIT with a pending rvalid_i -> all outputs 0, state IDLE, late rvalid_i ignored.
  - REQ-035 With IOB_SOC_SUT_BIST_INV_PASS_EN, len_i=4 -> writes P then ~P, 8 reads total, pass_o=1.

Source files
------------

// File: rtl/sram_bist_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_bist_pkg : FSM state encoding and error-counter width for sram_bist
// Rev 1.0
// ----------------------------------------------------------------------------
package sram_bist_pkg;

  localparam int ERR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sram_bist_cmp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_bist_cmp : pattern P(a)=PATTERN^a, optional inversion
//                 (IOB_SOC_SUT_BIST_INV_PASS_EN) and read-data mismatch flag
// Rev 1.0
// ----------------------------------------------------------------------------
module sram_bist_cmp #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 10,
  parameter logic [DATA_W-1:0] PATTERN = 32'hA5C3_0F96
) (
  input  logic [ADDR_W-1:0] addr_i,
`ifdef IOB_SOC_SUT_BIST_INV_PASS_EN
  input  logic              inv_i,
`endif
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] pat_o,
  output logic              mismatch_o
);

  logic [DATA_W-1:0] w_base;

  assign w_base = PATTERN ^ DATA_W'(addr_i);

`ifdef IOB_SOC_SUT_BIST_INV_PASS_EN
  assign pat_o = inv_i ? ~w_base : w_base;
`else
  assign pat_o = w_base;
`endif

  assign mismatch_o = (rdata_i != pat_o);

endmodule
`default_nettype wire

// File: rtl/sram_bist.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_bist : write-then-read SRAM self test over IOb-native bus;
//             IOB_SOC_SUT_BIST_INV_PASS_EN adds a second, inverted pass
// Rev 1.0
// ----------------------------------------------------------------------------
module sram_bist
  import sram_bist_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 10,
  parameter logic [DATA_W-1:0] PATTERN = 32'hA5C3_0F96
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic [ADDR_W:0]     len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [ERR_W-1:0]    err_cnt_o,
  output logic [ADDR_W-1:0]   fail_addr_o,
  output logic                avalid_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                rvalid_i,
  input  logic                ready_i
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fail_q, fail_d;
`ifdef IOB_SOC_SUT_BIST_INV_PASS_EN
  logic              inv_q, inv_d;
`endif

  logic [DATA_W-1:0] w_pat;
  logic              w_mismatch;
  logic              w_last;
  logic [ADDR_W:0]   w_len_in;

  sram_bist_cmp #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .PATTERN (PATTERN)
  ) u_cmp (
    .addr_i     (addr_q),
`ifdef IOB_SOC_SUT_BIST_INV_PASS_EN
    .inv_i      (inv_q),
`endif
    .rdata_i    (rdata_i),
    .pat_o      (w_pat),
    .mismatch_o (w_mismatch)
  );

  assign w_len_in = (len_i > LEN_MAX) ? LEN_MAX : len_i;
  assign w_last   = ({1'b0, addr_q} == (len_q - 1'b1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    err_d   = err_q;
    fail_d  = fail_q;
`ifdef IOB_SOC_SUT_BIST_INV_PASS_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          err_d   = '0;
          fail_d  = '0;
          addr_d  = '0;
          len_d   = w_len_in;
`ifdef IOB_SOC_SUT_BIST_INV_PASS_EN
          inv_d   = 1'b0;
`endif
          state_d = (len_i == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (ready_i) begin
          if (w_last) begin
            addr_d  = '0;
            state_d = S_RD_REQ;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        if (ready_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rvalid_i) begin
          if (w_mismatch) begin
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
            // err_q cannot return to zero mid-test, so zero marks the first miss
            if (err_q == '0) fail_d = addr_q;
          end
          if (w_last) begin
`ifdef IOB_SOC_SUT_BIST_INV_PASS_EN
            if (!inv_q) begin
              inv_d   = 1'b1;
              addr_d  = '0;
              state_d = S_WRITE;
            end else begin
              state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_RD_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

`ifdef IOB_SOC_SUT_BIST_INV_PASS_EN
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      inv_q <= 1'b0;
    end else if (cke_i) begin
      inv_q <= inv_d;
    end
  end
`endif

  assign avalid_o    = (state_q == S_WRITE) || (state_q == S_RD_REQ);
  assign addr_o      = avalid_o ? addr_q : '0;
  assign wdata_o     = (state_q == S_WRITE) ? w_pat : '0;
  assign wstrb_o     = (state_q == S_WRITE) ? '1 : '0;
  assign busy_o      = avalid_o || (state_q == S_RD_WAIT);
  assign done_o      = (state_q == S_DONE);
  assign pass_o      = done_o && (err_q == '0);
  assign err_cnt_o   = err_q;
  assign fail_addr_o = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bist.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sram_bist : sram_bist (ADDR_W=4) against a model SRAM and reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sram_bist;

  localparam int          AW    = 4;
  localparam int          WORDS = 16;
  localparam logic [31:0] PAT   = 32'hA5C3_0F96;
`ifdef IOB_SOC_SUT_BIST_INV_PASS_EN
  localparam int          PASSES = 2;
`else
  localparam int          PASSES = 1;
`endif

  logic          clk = 1'b0;
  logic          arst, cke, start, ready, inj_rv;
  logic [AW:0]   len;
  logic          busy, done, pass, avalid, rvalid;
  logic [15:0]   err_cnt;
  logic [AW-1:0] fail_addr, addr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;

  logic          m_rvalid = 1'b0;
  logic [31:0]   m_rdata  = '0;
  logic [31:0]   mem [WORDS];
  logic [15:0]   fault_mask = '0;
  logic          pend = 1'b0, prev_stall = 1'b0;
  logic [AW-1:0] pend_addr = '0, p_addr = '0;
  logic [31:0]   p_wdata = '0;
  logic [3:0]    p_wstrb = '0;
  int            cyc = 0, av_count = 0, npass = 0, ntotal = 0;
  logic [AW-1:0] wr_a[$], rd_a[$];
  logic [31:0]   wr_d[$];
  int            wr_c[$];

  assign rvalid = m_rvalid | inj_rv;
  assign rdata  = inj_rv ? 32'hDEAD_BEEF : m_rdata;

  always #5 clk = ~clk;

  sram_bist #(
    .DATA_W  (32),
    .ADDR_W  (AW),
    .PATTERN (PAT)
  ) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .cke_i       (cke),
    .start_i     (start),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .err_cnt_o   (err_cnt),
    .fail_addr_o (fail_addr),
    .avalid_o    (avalid),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .wstrb_o     (wstrb),
    .rdata_i     (rdata),
    .rvalid_i    (rvalid),
    .ready_i     (ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) begin
      npass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model SRAM: ready driven by the bench, read data returned one cycle after acceptance.
  always @(negedge clk) begin
    cyc++;
    m_rvalid = 1'b0;
    if (pend) begin
      m_rvalid = 1'b1;
      m_rdata  = mem[pend_addr] ^ {31'd0, fault_mask[pend_addr]};
      pend     = 1'b0;
    end
    if (prev_stall) begin
      chk("hold_avalid", avalid, 1);
      chk("hold_addr", addr, p_addr);
      chk("hold_wdata", wdata, p_wdata);
      chk("hold_wstrb", wstrb, p_wstrb);
    end
    if (avalid) av_count++;
    if (avalid && ready && cke && !arst) begin
      if (wstrb != '0) begin
        mem[addr] = wdata;
        wr_a.push_back(addr);
        wr_d.push_back(wdata);
        wr_c.push_back(cyc);
      end else begin
        pend      = 1'b1;
        pend_addr = addr;
        rd_a.push_back(addr);
      end
    end
    prev_stall = avalid && !(ready && cke) && !arst;
    p_addr     = addr;
    p_wdata    = wdata;
    p_wstrb    = wstrb;
  end

  task automatic run(input logic [AW:0] l, input logic [15:0] f, input bit rnd,
                     input int hold, output int cycles);
    bit held = 1'b0;
    wr_a.delete(); wr_d.delete(); wr_c.delete(); rd_a.delete();
    av_count   = 0;
    fault_mask = f;
    len        = l;
    start      = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 3000) begin
      len = (AW+1)'($urandom);
      if (rnd) begin
        ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
      end
      if (hold == 1 && !held && avalid && wstrb != '0 && addr == 2) begin
        held  = 1'b1;
        ready = 1'b0;
        repeat (3) begin
          tick();
          chk("stall_addr", addr, 2);
          chk("stall_wdata", wdata, PAT ^ 32'd2);
          chk("stall_avalid", avalid, 1);
        end
        ready = 1'b1;
      end
      if (hold == 2 && !held && avalid && wstrb != '0 && addr == 6) begin
        held = 1'b1;
        cke  = 1'b0;
        repeat (3) begin
          tick();
          chk("cke_addr", addr, 6);
          chk("cke_busy", busy, 1);
        end
        cke = 1'b1;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    ready = 1'b1;
    chk("done_seen", done, 1);
  endtask

  // Reference: P(a) pass then (optionally) ~P(a) pass over min(len,16) words.
  task automatic check_run(input int l, input logic [15:0] f, input bit b2b);
    int n = (l > WORDS) ? WORDS : l;
    int exp_err = 0;
    int exp_fail = 0;
    bit found = 1'b0;
    for (int a = 0; a < n; a++) begin
      if (f[a]) begin
        exp_err += PASSES;
        if (!found) begin
          exp_fail = a;
          found    = 1'b1;
        end
      end
    end
    chk("wr_count", wr_a.size(), n * PASSES);
    chk("rd_count", rd_a.size(), n * PASSES);
    for (int i = 0; i < wr_a.size() && i < n * PASSES; i++) begin
      logic [31:0] e;
      e = PAT ^ (i % n);
      if (i >= n) e = ~e;
      chk("wr_addr", wr_a[i], i % n);
      chk("wr_data", wr_d[i], e);
      if (b2b && (i % n) != 0) chk("wr_b2b", wr_c[i], wr_c[i-1] + 1);
    end
    for (int i = 0; i < rd_a.size() && i < n * PASSES; i++) chk("rd_addr", rd_a[i], i % n);
    if (n == 0) chk("len0_no_req", av_count, 0);
    chk("done", done, 1);
    chk("busy", busy, 0);
    chk("pass", pass, (exp_err == 0));
    chk("err_cnt", err_cnt, exp_err);
    chk("fail_addr", fail_addr, exp_fail);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          ncyc, k, l;
    logic [15:0] f;
    arst = 1'b1; cke = 1'b1; start = 1'b0; len = '0; ready = 1'b1; inj_rv = 1'b0;
    for (int i = 0; i < WORDS; i++) mem[i] = '0;
    tick();
    tick();
    chk("rst_avalid", avalid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_fail", fail_addr, 0);
    arst = 1'b0;
    tick();

    run(16, 16'h0000, 0, 0, ncyc); check_run(16, 16'h0000, 1);
    run(16, 16'h0020, 0, 0, ncyc); check_run(16, 16'h0020, 1);
    run(16, 16'h0000, 0, 1, ncyc); check_run(16, 16'h0000, 0);
    run(16, 16'h0000, 0, 2, ncyc); check_run(16, 16'h0000, 0);

    run(0, 16'hFFFF, 0, 0, ncyc);
    chk("len0_latency", (ncyc <= 2), 1);
    check_run(0, 16'hFFFF, 0);
    tick();
    tick();
    chk("len0_idle_req", av_count, 0);
    chk("len0_done_held", done, 1);

    run(4, 16'h0000, 0, 0, ncyc);  check_run(4, 16'h0000, 1);
    run(20, 16'h8001, 0, 0, ncyc); check_run(20, 16'h8001, 1);

    repeat (12) begin
      l = $urandom_range(0, 31);
      f = 16'($urandom);
      if ($urandom_range(0, 1) == 0) f = 16'h0000;
      run((AW+1)'(l), f, 1, 0, ncyc);
      check_run(l, f, 0);
    end

    // Reset while a read response is still in flight.
    fault_mask = '0;
    len   = 16;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(busy && !avalid) && k < 200) begin
      tick();
      k++;
    end
    chk("reach_rd_wait", (busy && !avalid), 1);
    arst = 1'b1;
    tick();
    arst   = 1'b0;
    chk("abort_avalid", avalid, 0);
    chk("abort_busy", busy, 0);
    inj_rv = 1'b1;
    tick();
    inj_rv = 1'b0;
    chk("late_avalid", avalid, 0);
    chk("late_addr", addr, 0);
    chk("late_wdata", wdata, 0);
    chk("late_wstrb", wstrb, 0);
    chk("late_busy", busy, 0);
    chk("late_done", done, 0);
    chk("late_pass", pass, 0);
    chk("late_err", err_cnt, 0);
    chk("late_fail", fail_addr, 0);

    run(16, 16'h0400, 0, 0, ncyc); check_run(16, 16'h0400, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire
